stream_rr_merge: RTL

- Parametrised N-channel stream merger: merges N input streams (data/stb/ack) onto one output stream using round-robin arbitration.
- Each output word is tagged with its source channel number.
- An optional packet mode holds the grant on one channel until that channel's last word.
- Also aggregates per-process exception lines into sticky flags. Sits in the user-design top level between process outputs and a shared peripheral port (e.g. rs232_tx, eth_tx).

---
 rtl/stream_rr_merge.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stream_rr_merge.sv
// N-channel round-robin stream merger with source-channel tagging, optional
// packet-hold arbitration and sticky per-process exception flags.
module stream_rr_merge #(
  parameter int N      = 4,
  parameter int WIDTH  = 32,
  parameter int CHAN_W = 2,
  parameter int PACKET = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N*WIDTH-1:0]  input_data,
  input  logic [N-1:0]        input_stb,
  input  logic [N-1:0]        input_last,
  output logic [N-1:0]        input_ack,
  output logic [WIDTH-1:0]    output_data,
  output logic [CHAN_W-1:0]   output_channel,
  output logic                output_last,
  output logic                output_stb,
  input  logic                output_ack,
  input  logic [N-1:0]        exception_in,
  output logic [N-1:0]        exception_flags,
  output logic                exception
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    ACK  = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [CHAN_W-1:0] PTR_RST = CHAN_W'(N - 1);

  state_t              state_q, state_d;
  logic [CHAN_W-1:0]   ptr_q, ptr_d;
  logic [CHAN_W-1:0]   cand_q, cand_d;
  logic                lock_q, lock_d;
  logic [N-1:0]        ack_q, ack_d;
  logic                stb_q, stb_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic                last_q, last_d;
  logic [N-1:0]        flags_q, flags_d;
  logic                exc_q, exc_d;

  logic                cand_found_s;
  logic [CHAN_W-1:0]   cand_idx_s;
  logic [CHAN_W-1:0]   scan_idx_s;

  // Candidate search: locked channel, else first requester after the pointer.
  always_comb begin
    cand_found_s = 1'b0;
    cand_idx_s   = '0;
    scan_idx_s   = '0;
    if (lock_q) begin
      cand_found_s = input_stb[ptr_q];
      cand_idx_s   = ptr_q;
    end else begin
      for (int k = 1; k <= N; k++) begin
        scan_idx_s = CHAN_W'((int'(ptr_q) + k) % N);
        if (!cand_found_s && input_stb[scan_idx_s]) begin
          cand_found_s = 1'b1;
          cand_idx_s   = scan_idx_s;
        end
      end
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cand_d  = cand_q;
    lock_d  = lock_q;
    ack_d   = '0;
    stb_d   = stb_q;
    data_d  = data_q;
    chan_d  = chan_q;
    last_d  = last_q;
    flags_d = flags_q | exception_in;
    exc_d   = |flags_q;
    case (state_q)
      ARB: begin
        if (cand_found_s) begin
          ack_d   = N'(1) << cand_idx_s;
          cand_d  = cand_idx_s;
          state_d = ACK;
        end else begin
          state_d = ARB;
        end
      end
      ACK: begin
        data_d  = input_data[int'(cand_q)*WIDTH +: WIDTH];
        chan_d  = cand_q;
        last_d  = input_last[cand_q];
        stb_d   = 1'b1;
        ptr_d   = cand_q;
        if (PACKET != 0) begin
          lock_d = ~input_last[cand_q];
        end else begin
          lock_d = 1'b0;
        end
        state_d = SEND;
      end
      SEND: begin
        if (output_ack) begin
          stb_d   = 1'b0;
          state_d = ARB;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        stb_d   = 1'b0;
        lock_d  = 1'b0;
        state_d = ARB;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= PTR_RST;
      cand_q  <= '0;
      lock_q  <= 1'b0;
      ack_q   <= '0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      last_q  <= 1'b0;
      flags_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cand_q  <= cand_d;
      lock_q  <= lock_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      last_q  <= last_d;
      flags_q <= flags_d;
      exc_q   <= exc_d;
    end
  end

  assign input_ack       = ack_q;
  assign output_stb      = stb_q;
  assign output_data     = data_q;
  assign output_channel  = chan_q;
  assign output_last     = last_q;
  assign exception_flags = flags_q;
  assign exception       = exc_q;

endmodule
